taxi_sreg_in: RTL and testbench

TAXI_SREG_IN -- requirements
Module: taxi_sreg_in

---
 rtl/taxi_sreg_in.sv | 156 +++++++++++++++
 tb/tb_taxi_sreg_in.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_sreg_in.sv
// Scans an external parallel-in/serial-out register (74HC165 style) into a COUNT-bit word.
// One word every (2*COUNT+2)*(PRESCALE+1) clk; no backpressure, data_valid is a single-cycle pulse.
module taxi_sreg_in #(
  parameter int COUNT    = 8,
  parameter int PRESCALE = 63,
  parameter int INVERT   = 1,
  parameter int REVERSE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sreg_q,
  output logic             sreg_ld_n,
  output logic             sreg_clk,
  output logic [COUNT-1:0] data_out,
  output logic             data_valid,
  output logic             data_changed
);

  localparam int PW = $clog2(PRESCALE + 1);
  localparam int BW = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    S_LOAD     = 2'd0,
    S_SHIFT_LO = 2'd1,
    S_SHIFT_HI = 2'd2,
    S_UPDATE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sync;
  logic [PW-1:0]    r_prescale;
  logic             w_tick;
  logic [BW-1:0]    r_bit_cnt;
  logic [BW-1:0]    w_bit_cnt_nxt;
  logic             w_last_bit;
  logic [COUNT-1:0] r_shift;
  logic [COUNT-1:0] w_shift_nxt;
  logic             r_upd_pend;
  logic             w_upd_pend_nxt;
  logic [COUNT-1:0] w_ordered;
  logic [COUNT-1:0] w_word;
  logic             r_ld_n;
  logic             r_sclk;
  logic [COUNT-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_data_changed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], sreg_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= PW'(PRESCALE);
    end else if (w_tick) begin
      r_prescale <= PW'(PRESCALE);
    end else begin
      r_prescale <= r_prescale - PW'(1);
    end
  end

  assign w_tick     = (r_prescale == '0);
  assign w_last_bit = (r_bit_cnt == BW'(COUNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LOAD;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_upd_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_upd_pend <= w_upd_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_upd_pend_nxt = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_bit_cnt_nxt = '0;
        if (w_tick) w_state_nxt = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (w_tick) begin
          w_shift_nxt = (r_shift << 1) | COUNT'(r_sync[1]);
          w_state_nxt = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (w_tick) begin
          w_bit_cnt_nxt  = r_bit_cnt + BW'(1);
          w_state_nxt    = w_last_bit ? S_UPDATE : S_SHIFT_LO;
          w_upd_pend_nxt = w_last_bit;
        end
      end
      S_UPDATE: begin
        if (w_tick) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Strobes are decoded from the next state and registered so the pins
  // change exactly with the state and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_n <= 1'b1;
      r_sclk <= 1'b0;
    end else begin
      r_ld_n <= (w_state_nxt != S_LOAD);
      r_sclk <= (w_state_nxt == S_SHIFT_HI);
    end
  end

  genvar g;
  generate
    for (g = 0; g < COUNT; g++) begin : g_order
      assign w_ordered[g] = r_shift[(REVERSE != 0) ? (COUNT - 1 - g) : g];
    end
  endgenerate

  assign w_word = (INVERT != 0) ? ~w_ordered : w_ordered;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out     <= '0;
      r_data_valid   <= 1'b0;
      r_data_changed <= 1'b0;
    end else if (r_upd_pend) begin
      r_data_out     <= w_word;
      r_data_valid   <= 1'b1;
      r_data_changed <= (w_word != r_data_out);
    end else begin
      r_data_valid   <= 1'b0;
      r_data_changed <= 1'b0;
    end
  end

  assign sreg_ld_n    = r_ld_n;
  assign sreg_clk     = r_sclk;
  assign data_out     = r_data_out;
  assign data_valid   = r_data_valid;
  assign data_changed = r_data_changed;

endmodule

// File: tb/tb_taxi_sreg_in.sv
// Bench for taxi_sreg_in: three 8-bit scanners (plain, reversed, inverted) fed by 74HC165 models,
// plus a COUNT=1 scanner on a static input.
module tb_taxi_sreg_in;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  // main (plain), rev (REVERSE=1), inv (INVERT=1), c1 (COUNT=1)
  logic       ld_m, sc_m, dv_m, dc_m, q_m;
  logic [7:0] do_m;
  logic       ld_r, sc_r, dv_r, dc_r, q_r;
  logic [7:0] do_r;
  logic       ld_i, sc_i, dv_i, dc_i, q_i;
  logic [7:0] do_i;
  logic       ld_c, sc_c, dv_c, dc_c;
  logic [0:0] do_c;

  logic [7:0] pat_m = 8'h00, pat_r = 8'h00, pat_i = 8'h00;
  logic [7:0] sr_m = 8'h00, sr_r = 8'h00, sr_i = 8'h00;

  taxi_sreg_in #(.COUNT(8), .PRESCALE(3), .INVERT(0), .REVERSE(0)) u_main (
    .clk(clk), .rst_n(rst_n), .sreg_q(q_m), .sreg_ld_n(ld_m), .sreg_clk(sc_m),
    .data_out(do_m), .data_valid(dv_m), .data_changed(dc_m));
  taxi_sreg_in #(.COUNT(8), .PRESCALE(3), .INVERT(0), .REVERSE(1)) u_rev (
    .clk(clk), .rst_n(rst_n), .sreg_q(q_r), .sreg_ld_n(ld_r), .sreg_clk(sc_r),
    .data_out(do_r), .data_valid(dv_r), .data_changed(dc_r));
  taxi_sreg_in #(.COUNT(8), .PRESCALE(3), .INVERT(1), .REVERSE(0)) u_inv (
    .clk(clk), .rst_n(rst_n), .sreg_q(q_i), .sreg_ld_n(ld_i), .sreg_clk(sc_i),
    .data_out(do_i), .data_valid(dv_i), .data_changed(dc_i));
  taxi_sreg_in #(.COUNT(1), .PRESCALE(3), .INVERT(0), .REVERSE(0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .sreg_q(1'b1), .sreg_ld_n(ld_c), .sreg_clk(sc_c),
    .data_out(do_c), .data_valid(dv_c), .data_changed(dc_c));

  // 74HC165: async parallel load while /PL low, shift toward Q7 on CP rise
  always @(posedge sc_m or negedge ld_m) if (!ld_m) sr_m <= pat_m; else sr_m <= {sr_m[6:0], 1'b0};
  always @(posedge sc_r or negedge ld_r) if (!ld_r) sr_r <= pat_r; else sr_r <= {sr_r[6:0], 1'b0};
  always @(posedge sc_i or negedge ld_i) if (!ld_i) sr_i <= pat_i; else sr_i <= {sr_i[6:0], 1'b0};
  assign q_m = sr_m[7];
  assign q_r = sr_r[7];
  assign q_i = sr_i[7];

  always @(negedge clk)
    if ((!ld_m && sc_m) || (!ld_r && sc_r) || (!ld_i && sc_i) || (!ld_c && sc_c)) viol++;

  typedef struct {
    logic [7:0] pat;
    logic [7:0] exp_out;
    logic       exp_chg;
  } vec_t;

  function automatic logic [7:0] ref_word(input logic [7:0] pat, input bit inv, input bit rev);
    logic [7:0] w;
    w = rev ? {<<{pat}} : pat;
    return inv ? ~w : w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (dv_m) ok = 1'b1;
    end
  endtask

  initial begin
    vec_t       tbl[6];
    int         n, k;
    bit         ok;
    logic [7:0] prev_m, prev_r, prev_i, e;
    int         ld_total, ld_runs, ld_bad, ld_run;
    int         sc_rises, sc_bad, sc_run;
    logic       prev_ld, prev_sc;

    tbl[0] = '{8'hA5, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 8'h3C, 1'b1};
    tbl[2] = '{8'h3C, 8'h3C, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 1'b1};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1};
    tbl[5] = '{8'h81, 8'h81, 1'b1};

    rst_n = 1'b0;
    pat_m = 8'hA5;
    pat_r = 8'h01;
    pat_i = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_ld_n", ld_m, 1);
    check("rst_sclk", sc_m, 0);
    check("rst_data_out", do_m, 0);
    check("rst_valid", dv_m, 0);
    check("rst_changed", dc_m, 0);
    check("rst_c1_ld_n", ld_c, 1);

    rst_n = 1'b1;
    wait_valid(100, n, ok);
    check("first_valid_seen", ok, 1);
    check("first_valid_within_72", (n <= 72), 1);
    check("first_out", do_m, 8'hA5);
    check("first_changed", dc_m, 1);
    check("rev_valid_aligned", dv_r, 1);
    check("rev_out_01", do_r, 8'h80);
    check("inv_out_ff", do_i, 8'h00);
    check("c1_out", do_c, 1);
    prev_m = 8'hA5;
    prev_r = 8'h80;
    prev_i = 8'h00;

    for (int t = 0; t < 6; t++) begin
      pat_m = tbl[t].pat;
      wait_valid(100, n, ok);
      check("tbl_valid_seen", ok, 1);
      check("tbl_interval", n, 72);
      check("tbl_out", do_m, tbl[t].exp_out);
      check("tbl_changed", dc_m, tbl[t].exp_chg);
    end
    prev_m = 8'h81;

    // COUNT=1 frame length
    k = 0;
    while (k < 40 && !dv_c) begin @(negedge clk); k++; end
    check("c1_valid_seen", dv_c, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (n < 40 && !dv_c);
    check("c1_interval", n, 16);
    check("c1_out_tracks", do_c, 1);
    check("c1_steady_unchanged", dc_c, 0);

    wait_valid(100, n, ok);
    check("resync_valid", ok, 1);
    check("resync_out", do_m, 8'h81);

    for (int f = 0; f < 20; f++) begin
      pat_m = ($urandom_range(0, 3) == 0) ? pat_m : 8'($urandom);
      pat_r = ($urandom_range(0, 3) == 0) ? pat_r : 8'($urandom);
      pat_i = ($urandom_range(0, 3) == 0) ? pat_i : 8'($urandom);
      wait_valid(100, n, ok);
      check("rnd_valid_seen", ok, 1);
      check("rnd_interval", n, 72);
      e = ref_word(pat_m, 1'b0, 1'b0);
      check("rnd_main_out", do_m, e);
      check("rnd_main_changed", dc_m, (e != prev_m));
      prev_m = e;
      e = ref_word(pat_r, 1'b0, 1'b1);
      check("rnd_rev_valid", dv_r, 1);
      check("rnd_rev_out", do_r, e);
      check("rnd_rev_changed", dc_r, (e != prev_r));
      prev_r = e;
      e = ref_word(pat_i, 1'b1, 1'b0);
      check("rnd_inv_valid", dv_i, 1);
      check("rnd_inv_out", do_i, e);
      check("rnd_inv_changed", dc_i, (e != prev_i));
      prev_i = e;
    end

    // Strobe protocol over 10 frames starting at a /PL fall
    pat_m = 8'hC3;
    prev_ld = ld_m;
    k = 0;
    ok = 1'b0;
    while (k < 200 && !ok) begin
      @(negedge clk);
      k++;
      if (prev_ld && !ld_m) ok = 1'b1;
      prev_ld = ld_m;
    end
    check("proto_ld_fall_seen", ok, 1);
    ld_total = 0; ld_runs = 0; ld_bad = 0; ld_run = 0;
    sc_rises = 0; sc_bad = 0; sc_run = 0;
    prev_sc = 1'b0;
    for (int c = 0; c < 720; c++) begin
      if (c > 0) @(negedge clk);
      if (!ld_m) begin
        ld_run++;
        ld_total++;
      end else if (ld_run != 0) begin
        ld_runs++;
        if (ld_run != 4) ld_bad++;
        ld_run = 0;
      end
      if (sc_m) begin
        sc_run++;
        if (!prev_sc) sc_rises++;
      end else if (sc_run != 0) begin
        if (sc_run != 4) sc_bad++;
        sc_run = 0;
      end
      prev_sc = sc_m;
    end
    check("proto_ld_low_total", ld_total, 40);
    check("proto_ld_runs", ld_runs, 10);
    check("proto_ld_run_len", ld_bad, 0);
    check("proto_sclk_pulses", sc_rises, 80);
    check("proto_sclk_len", sc_bad, 0);

    // Abort mid-frame during the fifth shift-clock high phase
    prev_ld = ld_m;
    prev_sc = sc_m;
    k = 0;
    n = -1;
    while (k < 200 && n < 5) begin
      @(negedge clk);
      k++;
      if (prev_ld && !ld_m) n = 0;
      else if (n >= 0 && sc_m && !prev_sc) n++;
      prev_ld = ld_m;
      prev_sc = sc_m;
    end
    check("abort_point_found", n, 5);
    check("abort_sclk_high_before", sc_m, 1);
    check("abort_out_before", do_m, 8'hC3);
    rst_n = 1'b0;
    #1;
    check("abort_sclk_low", sc_m, 0);
    check("abort_ld_n_high", ld_m, 1);
    check("abort_out_cleared", do_m, 0);
    check("abort_no_valid", dv_m, 0);
    pat_m = 8'h00;
    pat_r = 8'h35;
    pat_i = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(100, n, ok);
    check("post_abort_valid_seen", ok, 1);
    check("post_abort_full_frame", (n >= 65 && n <= 72), 1);
    check("post_abort_zero_out", do_m, 0);
    check("post_abort_zero_unchanged", dc_m, 0);
    check("post_abort_rev_out", do_r, 8'hAC);
    check("post_abort_rev_changed", dc_r, 1);
    check("post_abort_inv_out", do_i, 8'hFF);
    check("post_abort_inv_changed", dc_i, 1);

    check("ld_n_low_with_sclk_high", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
